led_pattern_gen: RTL
====================

// Module: led_pattern_gen
// PURPOSE
//  Generates the LED drive waveform that feeds led_control's i_clock input; its o_gnd-side companion is a constant 0.
//  Divides the system clock into ticks; a mode FSM produces OFF / ON / BLINK / BURST patterns.
//  Sits directly upstream of led_control in the board-level LED path.
// PARAMETERS
//  PRESCALE   25_000_000  system clocks per tick (>=2); set to 4 in simulation
//  PERIOD_W   8           width of i_period (half-period in ticks)
//  COUNT_W    4           width of i_count (blinks per burst)
//  PWM_BITS   4           PWM resolution; used only with LED_PWM_EN
// PORTS
//  i_clock    in   1         system clock, all logic on rising edge
//  i_reset    in   1         synchronous, active-high reset
//  i_load     in   1         1-cycle strobe: latch i_mode/i_period/i_count, restart pattern
//  i_mode     in   2         00 OFF, 01 ON, 10 BLINK, 11 BURST
//  i_period   in   PERIOD_W  half-period in ticks; 0 treated as 1
//  i_count    in   COUNT_W   number of HI+LO blinks in BURST
//  i_duty     in   PWM_BITS  on-phase brightness (port exists only with LED_PWM_EN)
//  o_led      out  1         LED drive (to led_control i_clock)
//  o_tick     out  1         1-cycle pulse every PRESCALE clocks
//  o_busy     out  1         high while in BURST_HI/BURST_LO
//  o_done     out  1         1-cycle pulse when a burst completes
// BEHAVIOUR
//  - Reset: state=S_OFF, prescaler=0, tick/half-period/burst counters=0, o_led=0, o_tick=0, o_busy=0, o_done=0.
//    i_reset wins over a simultaneous i_load. Reset mid-pattern aborts it with no o_done.
//  - Prescaler: counts 0..PRESCALE-1, wraps to 0; o_tick=1 on the cycle the count equals PRESCALE-1.
//  - i_load sampled at edge k: operands latched; prescaler and counters cleared; state set per mode.
//    All outputs are registered, so the new o_led value is visible right after edge k (1-cycle latency).
//    i_load mid-pattern aborts the current pattern and restarts it; an aborted burst gives no o_done.
//  - FSM states: S_OFF, S_ON, S_BLINK_HI, S_BLINK_LO, S_BURST_HI, S_BURST_LO.
//    OFF -> S_OFF, o_led=0.  ON -> S_ON, o_led=1.  Both are held until the next load or reset.
//    BLINK -> S_BLINK_HI. Each phase lasts max(i_period,1) ticks, then toggles HI<->LO. Free-running.
//    BURST with i_count=0 -> S_OFF immediately, and o_done pulses on the load edge.
//    BURST with i_count>0 -> S_BURST_HI; HI and LO phases each last max(i_period,1) ticks.
//    At the end of each LO phase the burst counter increments. When it reaches i_count:
//      state -> S_OFF, and o_done=1 for exactly that cycle; otherwise -> S_BURST_HI.
//  - Phase timing: the half-period counter advances only on o_tick.
//    A phase of P ticks is exactly P*PRESCALE clocks long.
//  - Counter widths equal the operand widths; compare with ==, no overflow is possible.
//    The period compare uses max(i_period,1) evaluated at latch time.
//  - o_busy = state is S_BURST_HI or S_BURST_LO.
// CONFIGURATION
//  LED_PWM_EN defined:
//    - Adds the i_duty port and a free-running PWM_BITS counter (one increment per clock).
//    - In an on-phase (S_ON, *_HI), o_led = (pwm_cnt < i_duty), registered; i_duty=0 gives o_led=0.
//    - Off-phases stay 0. Reset clears pwm_cnt.
//  LED_PWM_EN undefined: no i_duty port and no PWM counter; o_led=1 for the whole of each on-phase.
// STRUCTURE
//  - led_pkg: mode_t enum (MODE_OFF/ON/BLINK/BURST) and state_t enum (the six states above).
//  - Sub-module led_prescaler: PRESCALE counter producing o_tick, with a synchronous clear input driven by i_load.
//  - Top-level led_pattern_gen holds the FSM, phase/burst counters and optional PWM.
// TESTING (PRESCALE=4)
//  1) Reset held 3 cycles during BLINK -> o_led=0, o_busy=0, o_done=0 on the cycle after the reset edge; o_tick resumes 4 cycles after release.
//  2) Load BLINK, period=2 -> o_led high 8 clks, low 8 clks, repeating; o_tick every 4 clks.
//  3) Load BURST, period=1, count=3 -> three 4-high/4-low pulses; o_busy high 24 clks; o_done single pulse, then o_led=0.
//  4) Load BURST, count=0 -> o_led=0, o_busy=0, o_done=1 for exactly one cycle after the load edge.
//  5) i_load(ON) mid-burst -> o_led=1 after that edge, o_busy drops, no o_done; i_load+i_reset same edge -> reset state.
//  6) LED_PWM_EN, ON, i_duty=4 -> o_led high 4 of every 16 clks; i_duty=0 -> o_led stays 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: operating modes and FSM states.
// Latency: n/a (types only).
// Backpressure: none.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_ON       = 3'd1,
        S_BLINK_HI = 3'd2,
        S_BLINK_LO = 3'd3,
        S_BURST_HI = 3'd4,
        S_BURST_LO = 3'd5
    } state_t;

endpackage

// File: rtl/led_prescaler.sv
// Tick generator: counts 0..PRESCALE-1 and flags the last count with a 1-cycle o_tick.
// Latency: o_tick is registered; first tick PRESCALE-1 cycles after reset/clear.
// Backpressure: none; free-running, i_clear restarts the count from 0.
module led_prescaler #(
    parameter int PRESCALE = 25_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tick;

    assign w_cnt_nxt = (r_cnt == CNT_W'(PRESCALE - 1)) ? '0 : r_cnt + CNT_W'(1);
    assign o_tick    = r_tick;

    // Count and register the tick so it is high exactly while the count sits at PRESCALE-1.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= (w_cnt_nxt == CNT_W'(PRESCALE - 1));
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED drive pattern generator (OFF/ON/BLINK/BURST) feeding led_control; optional PWM dimming under LED_PWM_EN.
// Latency: all outputs registered; a load at edge k takes effect on the outputs right after edge k.
// Backpressure: none; i_load is accepted on any cycle and aborts/restarts the running pattern.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int PRESCALE = 25_000_000,
    parameter int PERIOD_W = 8,
    parameter int COUNT_W  = 4
`ifdef LED_PWM_EN
    ,
    parameter int PWM_BITS = 4
`endif
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [1:0]          i_mode,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [COUNT_W-1:0]  i_count,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS-1:0] i_duty,
`endif
    output logic                o_led,
    output logic                o_tick,
    output logic                o_busy,
    output logic                o_done
);

    state_t                r_state;
    logic [PERIOD_W-1:0]   r_period;
    logic [COUNT_W-1:0]    r_count;
    logic [PERIOD_W-1:0]   r_half;
    logic [COUNT_W-1:0]    r_burst;
    logic                  r_led;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic [PERIOD_W-1:0]   w_period_m1;
    logic                  w_phase_end;
    logic [COUNT_W-1:0]    w_burst_nxt;
    logic                  w_on_lvl;

    led_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (i_load),
        .o_tick  (w_tick)
    );

    // r_period is never 0 (clamped at latch time), so the subtraction cannot wrap.
    assign w_period_m1 = r_period - PERIOD_W'(1);
    assign w_phase_end = w_tick && (r_half == w_period_m1);
    assign w_burst_nxt = r_burst + COUNT_W'(1);

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] r_pwm;

    // Free-running PWM phase counter, one step per clock.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + PWM_BITS'(1);
        end
    end

    assign w_on_lvl = (r_pwm < i_duty);
`else
    assign w_on_lvl = 1'b1;
`endif

    // Mode FSM with phase/burst counters; outputs are registered alongside the state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_OFF;
            r_period <= PERIOD_W'(1);
            r_count  <= '0;
            r_half   <= '0;
            r_burst  <= '0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                r_period <= (i_period == '0) ? PERIOD_W'(1) : i_period;
                r_count  <= i_count;
                r_half   <= '0;
                r_burst  <= '0;
                case (mode_t'(i_mode))
                    MODE_OFF: begin
                        r_state <= S_OFF;
                        r_led   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    MODE_ON: begin
                        r_state <= S_ON;
                        r_led   <= w_on_lvl;
                        r_busy  <= 1'b0;
                    end
                    MODE_BLINK: begin
                        r_state <= S_BLINK_HI;
                        r_led   <= w_on_lvl;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        // An empty burst completes on the load edge itself.
                        if (i_count == '0) begin
                            r_state <= S_OFF;
                            r_led   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_BURST_HI;
                            r_led   <= w_on_lvl;
                            r_busy  <= 1'b1;
                        end
                    end
                endcase
            end else begin
                if (w_tick) begin
                    r_half <= w_phase_end ? '0 : r_half + PERIOD_W'(1);
                end
                case (r_state)
                    S_OFF: begin
                        r_led <= 1'b0;
                    end
                    S_ON: begin
                        r_led <= w_on_lvl;
                    end
                    S_BLINK_HI: begin
                        if (w_phase_end) begin
                            r_state <= S_BLINK_LO;
                            r_led   <= 1'b0;
                        end else begin
                            r_led   <= w_on_lvl;
                        end
                    end
                    S_BLINK_LO: begin
                        if (w_phase_end) begin
                            r_state <= S_BLINK_HI;
                            r_led   <= w_on_lvl;
                        end else begin
                            r_led   <= 1'b0;
                        end
                    end
                    S_BURST_HI: begin
                        if (w_phase_end) begin
                            r_state <= S_BURST_LO;
                            r_led   <= 1'b0;
                        end else begin
                            r_led   <= w_on_lvl;
                        end
                    end
                    S_BURST_LO: begin
                        r_led <= 1'b0;
                        if (w_phase_end) begin
                            r_burst <= w_burst_nxt;
                            if (w_burst_nxt == r_count) begin
                                r_state <= S_OFF;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_BURST_HI;
                                r_led   <= w_on_lvl;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_OFF;
                        r_led   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_led  = r_led;
    assign o_tick = w_tick;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
